// File: rtl/prod_collect_if.sv
// Handshake/bus bundle between the serial collector and its producer/consumer.
// Master drives start/shift_en/bit_in/ack; slave (the collector) returns q/done/busy/overrun.
interface prod_collect_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic             shift_en;
    logic             bit_in;
    logic             ack;
    logic [WIDTH-1:0] q;
    logic             done;
    logic             busy;
    logic             overrun;

    // done/ack: done stays high with q stable until ack is seen; done falls on the next edge.
    modport master (
        output start, shift_en, bit_in, ack,
        input  q, done, busy, overrun
    );

    modport slave (
        input  start, shift_en, bit_in, ack,
        output q, done, busy, overrun
    );
endinterface

// File: rtl/prod_collect.sv
// Serial-to-parallel collector for the shift-add multiplier: packs WIDTH shifted-out bits into q.
// Define PROD_COLLECT_MSB_FIRST_EN to shift left (first bit lands in q[WIDTH-1]); default is LSB-first.
module prod_collect #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    prod_collect_if.slave    bus,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] dbg_cnt
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] q_shifted;

`ifdef PROD_COLLECT_MSB_FIRST_EN
    assign q_shifted = {q_q[WIDTH-2:0], bus.bit_in};
`else
    assign q_shifted = {bus.bit_in, q_q[WIDTH-1:1]};
`endif

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;

        // start wins in every state, including over ack and a coincident shift_en.
        if (bus.start) begin
            state_d   = COLLECT;
            q_d       = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (bus.shift_en) begin
                        q_d   = q_shifted;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.shift_en) begin
                        overrun_d = 1'b1;
                    end
                    if (bus.ack) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end

        // Status flags are registered copies of the next state so they align with q.
        done_d = (state_d == HOLD);
        busy_d = (state_d == COLLECT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            q_q       <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;
    assign dbg_state   = state_q;
    assign dbg_cnt     = cnt_q;
endmodule
